// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port block RAM.
// Each grant issues exactly one registered command to the RAM; reads return
// through the shared rdata bus with a per-requester rvalid pulse.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  a_reset_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  wen0,
    input  logic                  wen1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    logic   ptr;     // requester favoured when both ask at once
    logic   owner;   // requester being served in ISSUE/RESP
    logic   winner;  // requester that would win if sampled this cycle

    // Round-robin choice: a lone requester always wins, a tie goes to ptr.
    // NOTE: the default assignment first keeps this block purely combinational
    // (no latch) on every path.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ptr;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

    // The RAM returns data straight onto the shared read bus.
    assign rdata = mem_rdata;
    assign busy  = (state != IDLE);

    // Arbitration FSM with registered command, ack and rvalid outputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
        end else begin
            // Acks and rvalids are single-cycle pulses unless set below.
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state)
                IDLE: begin
                    mem_wen <= 1'b0;
                    if (req0 || req1) begin
                        owner     <= winner;
                        ptr       <= ~winner;
                        ack0      <= ~winner;
                        ack1      <= winner;
                        mem_wen   <= winner ? wen1   : wen0;
                        mem_addr  <= winner ? addr1  : addr0;
                        mem_wdata <= winner ? wdata1 : wdata0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Clearing here guarantees a single RAM write per grant.
                    mem_wen <= 1'b0;
                    if (mem_wen) begin
                        state <= IDLE;
                    end else begin
                        rvalid0 <= ~owner;
                        rvalid1 <= owner;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_wen <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a block-RAM environment, a
// transaction-level reference model checked every cycle, directed scenarios
// with literal expectations, then randomized requesters with random resets.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          a_reset_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          wen0 = 1'b0, wen1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, rvalid0, rvalid1, busy, mem_wen;
    logic [DW-1:0] rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .req0      (req0),
        .req1      (req1),
        .wen0      (wen0),
        .wen1      (wen1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .busy      (busy),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Block RAM environment: synchronous write, one-cycle registered read.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    // ---------------- reference model (transaction schedule) ----------------
    logic [DW-1:0] m_mem [0:(1<<AW)-1];
    int            m_next_free = 0;   // first cycle the arbiter is idle again
    int            m_ack_cyc   = -1;  // cycle the ack/command is visible
    int            m_rv_cyc    = -1;  // cycle the read result is visible
    bit            m_ptr = 1'b0;
    bit            m_who = 1'b0;
    bit            m_wen = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]   = DW'(i * 37 + 5);
            m_mem[i] = DW'(i * 37 + 5);
        end
    end

    // Compare DUT outputs to the model on every falling edge, then let the
    // model sample the requests when it considers the arbiter idle.
    always @(negedge clk) begin
        if (!a_reset_n) begin
            check("rst_ack0",      32'(ack0),      32'd0);
            check("rst_ack1",      32'(ack1),      32'd0);
            check("rst_rvalid0",   32'(rvalid0),   32'd0);
            check("rst_rvalid1",   32'(rvalid1),   32'd0);
            check("rst_busy",      32'(busy),      32'd0);
            check("rst_mem_wen",   32'(mem_wen),   32'd0);
            check("rst_mem_addr",  32'(mem_addr),  32'd0);
            check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
            m_next_free = 0;
            m_ack_cyc   = -1;
            m_rv_cyc    = -1;
            m_ptr       = 1'b0;
        end else begin
            check("ack0",    32'(ack0),    32'((cyc == m_ack_cyc) && !m_who));
            check("ack1",    32'(ack1),    32'((cyc == m_ack_cyc) &&  m_who));
            check("mem_wen", 32'(mem_wen), 32'((cyc == m_ack_cyc) &&  m_wen));
            check("busy",    32'(busy),    32'(cyc < m_next_free));
            check("rvalid0", 32'(rvalid0), 32'((cyc == m_rv_cyc) && !m_who));
            check("rvalid1", 32'(rvalid1), 32'((cyc == m_rv_cyc) &&  m_who));
            if (cyc == m_rv_cyc) check("rdata", 32'(rdata), 32'(m_rdata));
            if (cyc == m_ack_cyc) begin
                check("mem_addr",  32'(mem_addr),  32'(m_addr));
                check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
                if (m_wen) m_mem[m_addr] = m_wdata;
            end
            if (cyc >= m_next_free && (req0 || req1)) begin
                m_who     = (req0 && req1) ? m_ptr : req1;
                m_ptr     = !m_who;
                m_wen     = m_who ? wen1   : wen0;
                m_addr    = m_who ? addr1  : addr0;
                m_wdata   = m_who ? wdata1 : wdata0;
                m_ack_cyc = cyc + 1;
                if (m_wen) begin
                    m_next_free = cyc + 2;
                    m_rv_cyc    = -1;
                end else begin
                    m_next_free = cyc + 3;
                    m_rv_cyc    = cyc + 2;
                    m_rdata     = m_mem[m_addr];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit            req_v [2];
    bit            wen_v [2];
    logic [AW-1:0] addr_v [2];
    logic [DW-1:0] wdata_v [2];
    bit            seen [2];

    task automatic new_cmd(input int i);
        req_v[i]   = 1'b1;
        wen_v[i]   = 1'($urandom_range(0, 1));
        addr_v[i]  = AW'($urandom_range(0, 15));
        wdata_v[i] = DW'($urandom);
    endtask

    task automatic apply_cmds();
        req0 = req_v[0]; wen0 = wen_v[0]; addr0 = addr_v[0]; wdata0 = wdata_v[0];
        req1 = req_v[1]; wen1 = wen_v[1]; addr1 = addr_v[1]; wdata1 = wdata_v[1];
    endtask

    int order[$];
    int overlap;
    int rst_hold;

    initial begin
        // Reset state, literal expectations.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("lit_rst_busy",    32'(busy),    32'd0);
        check("lit_rst_mem_wen", 32'(mem_wen), 32'd0);
        check("lit_rst_ack0",    32'(ack0),    32'd0);
        tick();
        a_reset_n = 1'b1;

        // Write 0xBEEF to 0x12 from requester 0.
        req0 = 1'b1; wen0 = 1'b1; addr0 = 8'h12; wdata0 = 16'hBEEF;
        @(negedge clk);
        tick(); req0 = 1'b0;
        @(negedge clk);
        check("lit_wr_ack0",      32'(ack0),      32'd1);
        check("lit_wr_mem_wen",   32'(mem_wen),   32'd1);
        check("lit_wr_mem_addr",  32'(mem_addr),  32'h12);
        check("lit_wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        tick();
        @(negedge clk);
        check("lit_wr_idle_busy",    32'(busy),    32'd0);
        check("lit_wr_no_rvalid0",   32'(rvalid0), 32'd0);
        check("lit_wr_wen_cleared",  32'(mem_wen), 32'd0);

        // Read it back.
        tick();
        req0 = 1'b1; wen0 = 1'b0; addr0 = 8'h12;
        @(negedge clk);
        tick(); req0 = 1'b0;
        @(negedge clk);
        check("lit_rd_ack0",  32'(ack0), 32'd1);
        check("lit_rd_busy1", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        check("lit_rd_rvalid0", 32'(rvalid0), 32'd1);
        check("lit_rd_rdata",   32'(rdata),   32'hBEEF);
        check("lit_rd_busy2",   32'(busy),    32'd1);
        tick();
        @(negedge clk);
        check("lit_rd_done_busy", 32'(busy), 32'd0);

        // Reset in the ISSUE cycle of a write aborts it.
        tick();
        req0 = 1'b1; wen0 = 1'b1; addr0 = 8'h12; wdata0 = 16'h1111;
        @(negedge clk);
        tick(); req0 = 1'b0;
        #1 a_reset_n = 1'b0;
        #1;
        check("lit_abort_ack0",    32'(ack0),    32'd0);
        check("lit_abort_mem_wen", 32'(mem_wen), 32'd0);
        tick();
        a_reset_n = 1'b1;
        req0 = 1'b1; wen0 = 1'b0; addr0 = 8'h12;
        @(negedge clk);
        tick(); req0 = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("lit_abort_rvalid0", 32'(rvalid0), 32'd1);
        check("lit_abort_rdata",   32'(rdata),   32'hBEEF);

        // Both requesters held high after reset: alternating grants.
        tick(); a_reset_n = 1'b0;
        tick(); a_reset_n = 1'b1;
        req0 = 1'b1; wen0 = 1'b0; addr0 = 8'h12;
        req1 = 1'b1; wen1 = 1'b0; addr1 = 8'h34;
        overlap = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ack0) order.push_back(0);
            if (ack1) order.push_back(1);
            if ((ack1 || rvalid1) && (ack0 || rvalid0)) overlap++;
            if (k < 11) tick();
        end
        check("lit_rr_count", 32'(order.size()), 32'd4);
        if (order.size() >= 4) begin
            check("lit_rr_g0", 32'(order[0]), 32'd0);
            check("lit_rr_g1", 32'(order[1]), 32'd1);
            check("lit_rr_g2", 32'(order[2]), 32'd0);
            check("lit_rr_g3", 32'(order[3]), 32'd1);
        end
        check("lit_rr_overlap", 32'(overlap), 32'd0);
        tick();
        req0 = 1'b0; req1 = 1'b0;

        // Requester 1 reading continuously: one access every 3 cycles.
        tick();
        req1 = 1'b1; wen1 = 1'b0; addr1 = 8'h34;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("lit_r1_ack1",    32'(ack1),    32'((k % 3) == 1));
            check("lit_r1_rvalid1", 32'(rvalid1), 32'((k % 3) == 2));
            if (k < 8) tick();
        end
        tick();
        req1 = 1'b0;

        // Randomized requesters with occasional resets.
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; wen_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0; seen[i] = 1'b0;
        end
        rst_hold = 0;
        repeat (3000) begin
            tick();
            if (!a_reset_n) begin
                if (rst_hold == 0) a_reset_n = 1'b1;
                else rst_hold--;
            end else if ($urandom_range(0, 199) == 0) begin
                a_reset_n = 1'b0;
                rst_hold  = $urandom_range(0, 2);
            end
            for (int i = 0; i < 2; i++) begin
                if (seen[i]) begin
                    seen[i] = 1'b0;
                    if ($urandom_range(0, 1) == 1) new_cmd(i);
                    else req_v[i] = 1'b0;
                end else if (req_v[i]) begin
                    // Cancel only while the request cannot yet have been sampled.
                    if (cyc >= m_next_free && $urandom_range(0, 7) == 0) req_v[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    new_cmd(i);
                end
            end
            apply_cmds();
            @(negedge clk);
            seen[0] = ack0;
            seen[1] = ack1;
        end

        tick();
        a_reset_n = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
